// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and 640x480 defaults for the frame capture path and display address generator.
package frame_capture_ctrl_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_ADDR_W       = 18;
  localparam int DEF_FRAME_PIXELS = 153600;
  localparam int DEF_SKIP_FRAMES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    WAIT_FS,
    CAPTURE,
    DONE
  } cap_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Frame buffer single-port bus plus the display read request/response channel.
interface frame_capture_ctrl_if
  import frame_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  rd_req, rd_addr, mem_rdata,
    output rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output rd_req, rd_addr, mem_rdata,
    input  rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/frame_capture_ctrl_buffer_port_arb.sv
// Single-port buffer mux: a pending capture write always wins; display reads fill idle cycles.
module frame_capture_ctrl_buffer_port_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic rd_valid_q, rd_valid_d;

  always_comb begin
    rd_ack     = resetn && rd_req && !wr_en;
    mem_we     = wr_en;
    mem_wdata  = wr_en ? wr_data : '0;
    mem_addr   = wr_en ? wr_addr : (rd_ack ? rd_addr : '0);
    rd_valid_d = rd_ack;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  // RAM read data lands exactly in the cycle after the granted address.
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_rdata : '0;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Armed, frame-aligned, bounded single-shot capture of one camera frame into the shared buffer.
//   state   | meaning
//   IDLE    | no capture requested since reset
//   SKIP    | discarding SKIP_FRAMES complete frames while the sensor settles
//   WAIT_FS | waiting for the next frame_start to align the capture
//   CAPTURE | writing pixels to addresses 0..FRAME_PIXELS-1
//   DONE    | frame (complete or truncated) held in buffer
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int SKIP_FRAMES  = DEF_SKIP_FRAMES
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  frame_capture_ctrl_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              short_frame,
  output logic              overflow,
  output logic [ADDR_W:0]   pix_count
);

  localparam int              SKIP_W = cnt_width(SKIP_FRAMES);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(FRAME_PIXELS);

  cap_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      skip_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    short_d = short_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = (SKIP_FRAMES == 0) ? WAIT_FS : SKIP;
          skip_d  = SKIP_W'(SKIP_FRAMES);
          cnt_d   = '0;
          done_d  = 1'b0;
          short_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      SKIP: begin
        if (frame_end) begin
          if (skip_q == SKIP_W'(1)) begin
            state_d = WAIT_FS;
          end
          skip_d = skip_q - 1'b1;
        end
      end
      WAIT_FS: begin
        if (frame_start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CAPTURE: begin
        // A second frame_start without frame_end means the previous frame was lost; restart at 0.
        if (frame_start && !frame_end) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else begin
          if (pix_valid) begin
            if (cnt_q < FULL) begin
              we_d    = 1'b1;
              waddr_d = cnt_q[ADDR_W-1:0];
              wdata_d = pix_data;
              cnt_d   = cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (frame_end) begin
            state_d = DONE;
            done_d  = 1'b1;
            short_d = (cnt_d < FULL);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == SKIP) || (state_q == WAIT_FS) || (state_q == CAPTURE);
  assign done        = done_q;
  assign short_frame = short_q;
  assign overflow    = ovf_q;
  assign pix_count   = cnt_q;

  frame_capture_ctrl_buffer_port_arb #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (we_q),
    .wr_addr  (waddr_q),
    .wr_data  (wdata_q),
    .rd_req   (bus.rd_req),
    .rd_addr  (bus.rd_addr),
    .rd_ack   (bus.rd_ack),
    .rd_valid (bus.rd_valid),
    .rd_data  (bus.rd_data),
    .mem_addr (bus.mem_addr),
    .mem_we   (bus.mem_we),
    .mem_wdata(bus.mem_wdata),
    .mem_rdata(bus.mem_rdata)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: random pixels and display reads against a frame-level model.
module tb_frame_capture_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int FP = 16;
  localparam int SK = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    bit            known;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic resetn, arm, frame_start, frame_end, pix_valid;
  logic [DW-1:0] pix_data;
  logic busy, done, short_frame, overflow;
  logic [AW:0] pix_count;

  frame_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  frame_capture_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP), .SKIP_FRAMES(SK)
  ) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .frame_start(frame_start),
    .frame_end(frame_end), .pix_valid(pix_valid), .pix_data(pix_data),
    .bus(bus), .busy(busy), .done(done), .short_frame(short_frame),
    .overflow(overflow), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  // Buffer RAM: read data registered one cycle after the address.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int  checks = 0;
  int  failures = 0;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  logic [DW-1:0] ref_mem [256];
  bit  ref_ok [256];
  bit  mon_on = 1'b0;
  bit  last_ack = 1'b0;
  bit  rd_en = 1'b0;
  int  ack_cnt = 0;
  int  m_cnt = 0;
  bit  m_ovf = 1'b0;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: pops expected writes/reads whenever the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk(bus.rd_ack === (resetn && bus.rd_req && !bus.mem_we), "rd_ack_rule",
            int'(bus.rd_ack), int'(resetn && bus.rd_req && !bus.mem_we));
        if (bus.mem_we) begin
          if (exp_wr.size() == 0) begin
            chk(1'b0, "unexpected_write_addr", int'(bus.mem_addr), -1);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk(bus.mem_addr === e.addr, "write_addr", int'(bus.mem_addr), int'(e.addr));
            chk(bus.mem_wdata === e.data, "write_data", int'(bus.mem_wdata), int'(e.data));
            ref_mem[e.addr] = e.data;
            ref_ok[e.addr]  = 1'b1;
          end
        end
        if (bus.rd_valid) begin
          if (exp_rd.size() == 0) begin
            chk(1'b0, "unexpected_rd_valid", int'(bus.rd_data), -1);
          end else begin
            rd_t r;
            r = exp_rd.pop_front();
            if (r.known) chk(bus.rd_data === r.data, "rd_data", int'(bus.rd_data), int'(r.data));
          end
        end
        if (bus.rd_ack) begin
          exp_rd.push_back('{known: ref_ok[bus.rd_addr], data: ref_mem[bus.rd_addr]});
          ack_cnt++;
        end
        last_ack = bus.rd_ack;
      end
    end
  end

  task automatic drive(input bit a, input bit fs, input bit fe, input bit pv, input logic [DW-1:0] pd);
    if (!rd_en) begin
      bus.rd_req = 1'b0;
    end else if (!bus.rd_req || last_ack) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'($urandom_range(0, FP - 1));
    end
    arm = a; frame_start = fs; frame_end = fe; pix_valid = pv; pix_data = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input bit capt, input logic [DW-1:0] d);
    if (capt) begin
      if (m_cnt < FP) begin
        exp_wr.push_back('{addr: AW'(m_cnt), data: d});
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // gap: 0 back-to-back, 1 every other cycle, 2 random
  task automatic pixels(input int n, input bit capt, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      push_pix(capt, d);
      drive(0, 0, 0, 1, d);
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) drive(0, 0, 0, 0, '0);
    end
  endtask

  task automatic skip_frames();
    for (int f = 0; f < SK; f++) begin
      drive(0, 1, 0, 0, '0);
      pixels(FP, 1'b0, 2);
      drive(0, 0, 1, 0, '0);
      if (f == 0) drive(1, 0, 0, 0, '0);
    end
    pixels(3, 1'b0, 0);
  endtask

  task automatic begin_capture();
    m_cnt = 0;
    m_ovf = 1'b0;
    drive(0, 1, 0, 0, '0);
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_short,
                              input bit e_ovf, input int e_cnt, input bit e_busy);
    chk(done === e_done, {tag, "_done"}, int'(done), int'(e_done));
    chk(short_frame === e_short, {tag, "_short_frame"}, int'(short_frame), int'(e_short));
    chk(overflow === e_ovf, {tag, "_overflow"}, int'(overflow), int'(e_ovf));
    chk(int'(pix_count) == e_cnt, {tag, "_pix_count"}, int'(pix_count), e_cnt);
    chk(busy === e_busy, {tag, "_busy"}, int'(busy), int'(e_busy));
  endtask

  initial begin
    int a0;
    logic [DW-1:0] d;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end
    resetn = 1'b0; arm = 0; frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    check_status("reset", 0, 0, 0, 0, 0);
    chk(bus.mem_we === 1'b0, "reset_mem_we", int'(bus.mem_we), 0);
    chk(bus.rd_valid === 1'b0, "reset_rd_valid", int'(bus.rd_valid), 0);
    resetn = 1'b1;
    drive(0, 0, 0, 0, '0);

    // Full frame after skipping, pixels back-to-back with reads held: no grants.
    drive(1, 0, 0, 0, '0);
    check_status("armed", 0, 0, 0, 0, 1);
    skip_frames();
    begin_capture();
    d = DW'($urandom);
    push_pix(1'b1, d);
    drive(0, 0, 0, 1, d);
    a0 = ack_cnt;
    rd_en = 1'b1;
    pixels(FP - 1, 1'b1, 0);
    rd_en = 1'b0;
    drive(0, 0, 1, 0, '0);
    chk(ack_cnt == a0, "starved_reads", ack_cnt - a0, 0);
    check_status("full", 1, 0, m_ovf, m_cnt, 0);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    // Overflow: 20 pixels into a 16-pixel buffer, reads interleaved.
    drive(1, 0, 0, 0, '0);
    skip_frames();
    begin_capture();
    rd_en = 1'b1;
    pixels(FP + 4, 1'b1, 2);
    drive(0, 0, 1, 0, '0);
    rd_en = 1'b0;
    check_status("overflow", 1, 0, 1, FP, 0);
    chk(m_ovf && m_cnt == FP, "model_overflow", m_cnt, FP);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    // Short frame, last pixel coincident with frame_end, reads in gaps.
    drive(1, 0, 0, 0, '0);
    check_status("rearm", 0, 0, 0, 0, 1);
    skip_frames();
    begin_capture();
    a0 = ack_cnt;
    rd_en = 1'b1;
    pixels(9, 1'b1, 1);
    d = DW'($urandom);
    push_pix(1'b1, d);
    drive(0, 0, 1, 1, d);
    rd_en = 1'b0;
    check_status("short", 1, 1, 0, 10, 0);
    chk(ack_cnt > a0, "reads_in_gaps", ack_cnt - a0, 1);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    // Reset in CAPTURE after 5 pixels, then a normal capture.
    drive(1, 0, 0, 0, '0);
    skip_frames();
    begin_capture();
    pixels(5, 1'b1, 0);
    resetn = 1'b0;
    drive(0, 0, 0, 0, '0);
    resetn = 1'b1;
    chk(bus.mem_we === 1'b0, "reset_mid_mem_we", int'(bus.mem_we), 0);
    check_status("reset_mid", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, '0);
    skip_frames();
    begin_capture();
    rd_en = 1'b1;
    pixels(FP, 1'b1, 2);
    drive(0, 0, 1, 0, '0);
    rd_en = 1'b0;
    check_status("after_reset", 1, 0, 0, FP, 0);
    drive(0, 0, 0, 0, '0);

    // Missing frame_end: second frame_start restarts at address 0.
    drive(1, 0, 0, 0, '0);
    skip_frames();
    begin_capture();
    pixels(6, 1'b1, 0);
    chk(int'(pix_count) == 6, "pre_restart_count", int'(pix_count), 6);
    begin_capture();
    rd_en = 1'b1;
    pixels(FP, 1'b1, 2);
    drive(0, 0, 1, 0, '0);
    rd_en = 1'b0;
    check_status("restart", 1, 0, 0, FP, 0);

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, '0);
    chk(exp_wr.size() == 0, "pending_writes", exp_wr.size(), 0);
    chk(exp_rd.size() == 0, "pending_reads", exp_rd.size(), 0);
    for (int i = 0; i < FP; i++) begin
      if (ref_ok[i]) chk(ram[i] === ref_mem[i], "final_mem", int'(ram[i]), int'(ref_mem[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences single-shot capture of one camera frame into the shared pixel frame buffer. Arbitrates that buffer's single port between the capture write stream and the HDMI display read stream. Sits between the CSI packet/raw8 unpacker and the buffer RAM. Replaces ad-hoc savePic/startup counters with an armed, frame-aligned, bounded capture.

Parameters:
DATA_W, 8, pixel width written to buffer
ADDR_W, 18, buffer address width
FRAME_PIXELS, 153600, pixels per captured frame (640x480 raw8 packed 2/word budget)
SKIP_FRAMES, 4, complete frames discarded after arm before capture (sensor settling)

Ports:
clk  in  1  pixel clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
arm  in  1  1-cycle pulse: start a capture sequence
frame_start  in  1  1-cycle pulse from packet decoder
frame_end  in  1  1-cycle pulse from packet decoder
pix_valid  in  1  pixel strobe, 1 cycle per pixel
pix_data  in  DATA_W  pixel value
rd_req  in  1  display read request, held until rd_ack
rd_addr  in  ADDR_W  display read address
rd_ack  out  1  request granted this cycle
rd_valid  out  1  rd_data valid (1 cycle after rd_ack)
rd_data  out  DATA_W  read data
mem_addr  out  ADDR_W  buffer address
mem_we  out  1  buffer write enable
mem_wdata  out  DATA_W  buffer write data
mem_rdata  in  DATA_W  buffer read data, registered 1 cycle after address
busy  out  1  state is not IDLE/DONE
done  out  1  a complete or truncated frame is in buffer
short_frame  out  1  last capture ended before FRAME_PIXELS
overflow  out  1  pixels dropped past FRAME_PIXELS
pix_count  out  ADDR_W+1  pixels written in last/current capture

Behaviour:
- Reset (resetn=0 at edge): state IDLE; all outputs 0; mem_we deasserts on that same edge; counters cleared. Reset mid-capture abandons the frame; done stays 0.
- States: IDLE, SKIP, WAIT_FS, CAPTURE, DONE.
- IDLE/DONE: arm -> SKIP (SKIP_FRAMES=0 -> WAIT_FS); clears done, short_frame, overflow, pix_count, skip counter. arm in SKIP/WAIT_FS/CAPTURE ignored.
- SKIP: count frame_end pulses; after SKIP_FRAMES-th -> WAIT_FS. frame_start on the transition cycle is not used.
- WAIT_FS: frame_start -> CAPTURE, write address 0. Pixels before frame_start are ignored.
- CAPTURE: each pix_valid with pix_count<FRAME_PIXELS -> mem_we=1, mem_addr=pix_count, mem_wdata=pix_data registered (1-cycle latency pixel->write); pix_count+1. pix_valid at pix_count=FRAME_PIXELS -> no write, overflow=1 (sticky).
- CAPTURE exit: frame_end -> DONE, done=1. short_frame=1 if pix_count<FRAME_PIXELS. A pix_valid coinciding with frame_end is still written. A frame_start in CAPTURE (missing frame_end) restarts: pix_count=0, address 0, overflow cleared.
- Arbitration: a pending capture write always wins. rd_ack=1 only in a cycle with mem_we=0 and rd_req=1; that cycle mem_addr=rd_addr. rd_valid=1 next cycle with rd_data=mem_rdata. Reads are permitted in every state; data during capture may be partially new.
- pix_valid at most every other cycle guarantees read bandwidth. Back-to-back pix_valid starves reads; no pixel is ever dropped for a read.
- pix_count saturates at FRAME_PIXELS. No wrap.

Decomposition:
- Shared package: state enum (IDLE, SKIP, WAIT_FS, CAPTURE, DONE) and FRAME_PIXELS/ADDR_W defaults for 640x480, also used by the display address generator.
- One natural sub-module: buffer_port_arb (write-priority single-port mux plus rd_valid pipeline). The FSM and counters stay in the top.

Test Plan:
- SKIP_FRAMES=2, arm, 3 frames of 16 pixels (FRAME_PIXELS=16): only the 3rd frame is written to addr 0..15 -> done=1, short_frame=0, pix_count=16.
- 20 pixels in a 16-pixel frame -> addresses 0..15 written, overflow=1, last 4 pixels absent from memory, pix_count=16.
- frame_end after 10 pixels -> DONE, short_frame=1, pix_count=10, addr 10..15 untouched.
- rd_req held during pixels every cycle -> rd_ack=0 throughout. On pixels every other cycle -> rd_ack in gaps, rd_valid next cycle with the correct stored value.
- resetn low in CAPTURE after 5 pixels -> next cycle mem_we=0, state IDLE, done=0, pix_count=0. A later arm captures normally.
- frame_start, 6 pixels, frame_start again, 16 pixels, frame_end -> done, pix_count=16, addr 0..5 hold second-frame data.
